bsg_vanilla_remote_load_wb_queue: RTL and testbench

- Parametrised writeback queue for remote load responses returning from the manycore network to the vanilla core.
- Buffers up to els_p responses in arrival order.
- Performs byte/hex/word extraction with sign or zero extension at enqueue.
- Steers the queue head to either the integer or the FP regfile writeback port. Supports a 32-bit or 64-bit network data path feeding a 32-bit RV32 regfile.

---
 rtl/bsg_vanilla_remote_load_wb_queue.sv | 155 +++++++++++++++
 tb/tb_bsg_vanilla_remote_load_wb_queue.sv | 240 ++++++++++++++++++++++++
 2 files changed

// File: rtl/bsg_vanilla_remote_load_wb_queue.sv
// Writeback queue for remote load responses: aligns/extends data at enqueue and steers the
// head entry to either the integer or the FP regfile writeback port.
module bsg_vanilla_remote_load_wb_queue #(
  parameter int data_width_p   = 32,
  parameter int els_p          = 4,
  parameter int reg_id_width_p = 5,
  localparam int part_sel_width_lp = $clog2(data_width_p / 8),
  localparam int count_width_lp    = $clog2(els_p + 1)
) (
  input  logic                         clk_i,
  input  logic                         reset_n_i,

  input  logic                         v_i,
  output logic                         ready_o,
  input  logic                         float_wb_i,
  input  logic [reg_id_width_p-1:0]    reg_id_i,
  input  logic                         is_unsigned_op_i,
  input  logic                         is_byte_op_i,
  input  logic                         is_hex_op_i,
  input  logic [part_sel_width_lp-1:0] part_sel_i,
  input  logic [data_width_p-1:0]      data_i,

  output logic                         int_v_o,
  output logic [reg_id_width_p-1:0]    int_rd_o,
  output logic [31:0]                  int_data_o,
  input  logic                         int_yumi_i,

  output logic                         float_v_o,
  output logic [reg_id_width_p-1:0]    float_rd_o,
  output logic [31:0]                  float_data_o,
  input  logic                         float_yumi_i,

  output logic [count_width_lp-1:0]    count_o,
  output logic                         float_pending_o
);

  localparam int ptr_width_lp = $clog2(els_p);

  logic [31:0]               r_data  [els_p];
  logic [reg_id_width_p-1:0] r_rd    [els_p];
  logic                      r_float [els_p];

  logic [ptr_width_lp-1:0]   r_rptr, r_wptr;
  logic [count_width_lp-1:0] r_count, r_fcount;
  logic                      r_ready;

  logic                      w_enq, w_pop, w_empty, w_head_float;
  logic                      w_int_v, w_float_v, w_float_pop, w_float_enq;
  logic [count_width_lp-1:0] w_count_d, w_fcount_d;
  logic [ptr_width_lp-1:0]   w_rptr_inc, w_wptr_inc;
  logic [7:0]                w_byte;
  logic [15:0]               w_hex;
  logic [31:0]               w_word, w_aligned;

  // Lane extraction; only the aligned 32-bit result is stored.
  always_comb begin
    w_byte = 8'(data_i >> {part_sel_i, 3'b000});
    w_hex  = 16'(data_i >> {part_sel_i[part_sel_width_lp-1:1], 4'b0000});
    if (data_width_p == 64) begin
      w_word = 32'(data_i >> {part_sel_i[part_sel_width_lp-1], 5'b00000});
    end else begin
      w_word = 32'(data_i);
    end
    if (float_wb_i || !(is_byte_op_i || is_hex_op_i)) begin
      w_aligned = w_word;
    end else if (is_byte_op_i) begin
      w_aligned = {{24{~is_unsigned_op_i & w_byte[7]}}, w_byte};
    end else begin
      w_aligned = {{16{~is_unsigned_op_i & w_hex[15]}}, w_hex};
    end
  end

  always_comb begin
    w_empty      = (r_count == '0);
    w_head_float = r_float[r_rptr];
    w_int_v      = !w_empty && !w_head_float;
    w_float_v    = !w_empty && w_head_float;
    w_float_pop  = w_float_v && float_yumi_i;
    w_pop        = (w_int_v && int_yumi_i) || w_float_pop;
    w_enq        = v_i && r_ready;
    w_float_enq  = w_enq && float_wb_i;

    w_rptr_inc = (r_rptr == ptr_width_lp'(els_p - 1)) ? '0 : r_rptr + ptr_width_lp'(1);
    w_wptr_inc = (r_wptr == ptr_width_lp'(els_p - 1)) ? '0 : r_wptr + ptr_width_lp'(1);

    w_count_d = r_count;
    if (w_enq && !w_pop) begin
      w_count_d = r_count + count_width_lp'(1);
    end else if (!w_enq && w_pop) begin
      w_count_d = r_count - count_width_lp'(1);
    end

    w_fcount_d = r_fcount;
    if (w_float_enq && !w_float_pop) begin
      w_fcount_d = r_fcount + count_width_lp'(1);
    end else if (!w_float_enq && w_float_pop) begin
      w_fcount_d = r_fcount - count_width_lp'(1);
    end
  end

  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      r_rptr   <= '0;
      r_wptr   <= '0;
      r_count  <= '0;
      r_fcount <= '0;
      r_ready  <= 1'b0;
    end else begin
      if (w_pop) r_rptr <= w_rptr_inc;
      if (w_enq) r_wptr <= w_wptr_inc;
      r_count  <= w_count_d;
      r_fcount <= w_fcount_d;
      r_ready  <= (w_count_d != count_width_lp'(els_p));
    end
  end

  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      for (int i = 0; i < els_p; i++) begin
        r_data[i]  <= '0;
        r_rd[i]    <= '0;
        r_float[i] <= 1'b0;
      end
    end else if (w_enq) begin
      r_data[r_wptr]  <= w_aligned;
      r_rd[r_wptr]    <= reg_id_i;
      r_float[r_wptr] <= float_wb_i;
    end
  end

  // rd/data are gated by their valid so idle ports (and reset) present zero.
  always_comb begin
    ready_o         = r_ready;
    count_o         = r_count;
    float_pending_o = (r_fcount != '0);
    int_v_o         = w_int_v;
    float_v_o       = w_float_v;
    int_rd_o        = w_int_v ? r_rd[r_rptr] : '0;
    int_data_o      = w_int_v ? r_data[r_rptr] : '0;
    float_rd_o      = w_float_v ? r_rd[r_rptr] : '0;
    float_data_o    = w_float_v ? r_data[r_rptr] : '0;
  end

`ifndef SYNTHESIS
  a_no_overflow: assert property (@(posedge clk_i) disable iff (!reset_n_i)
    !(v_i && !r_ready));
  a_byte_hex_excl: assert property (@(posedge clk_i) disable iff (!reset_n_i)
    !(v_i && is_byte_op_i && is_hex_op_i));
  a_int_yumi_valid: assert property (@(posedge clk_i) disable iff (!reset_n_i)
    !(int_yumi_i && !w_int_v));
  a_float_yumi_valid: assert property (@(posedge clk_i) disable iff (!reset_n_i)
    !(float_yumi_i && !w_float_v));
`endif

endmodule

// File: tb/tb_bsg_vanilla_remote_load_wb_queue.sv
// Bench for bsg_vanilla_remote_load_wb_queue (64-bit data, 3 entries): directed cases plus
// randomized traffic checked against a queue-based reference model.
module tb_bsg_vanilla_remote_load_wb_queue;

  localparam int DW  = 64;
  localparam int ELS = 3;
  localparam int RW  = 5;

  logic          clk_i = 1'b0;
  logic          reset_n_i;
  logic          v_i, ready_o, float_wb_i, is_unsigned_op_i, is_byte_op_i, is_hex_op_i;
  logic [RW-1:0] reg_id_i, int_rd_o, float_rd_o;
  logic [2:0]    part_sel_i;
  logic [DW-1:0] data_i;
  logic          int_v_o, int_yumi_i, float_v_o, float_yumi_i, float_pending_o;
  logic [31:0]   int_data_o, float_data_o;
  logic [1:0]    count_o;

  bsg_vanilla_remote_load_wb_queue #(
    .data_width_p  (DW),
    .els_p         (ELS),
    .reg_id_width_p(RW)
  ) dut (
    .clk_i           (clk_i),
    .reset_n_i       (reset_n_i),
    .v_i             (v_i),
    .ready_o         (ready_o),
    .float_wb_i      (float_wb_i),
    .reg_id_i        (reg_id_i),
    .is_unsigned_op_i(is_unsigned_op_i),
    .is_byte_op_i    (is_byte_op_i),
    .is_hex_op_i     (is_hex_op_i),
    .part_sel_i      (part_sel_i),
    .data_i          (data_i),
    .int_v_o         (int_v_o),
    .int_rd_o        (int_rd_o),
    .int_data_o      (int_data_o),
    .int_yumi_i      (int_yumi_i),
    .float_v_o       (float_v_o),
    .float_rd_o      (float_rd_o),
    .float_data_o    (float_data_o),
    .float_yumi_i    (float_yumi_i),
    .count_o         (count_o),
    .float_pending_o (float_pending_o)
  );

  always #5 clk_i = ~clk_i;

  typedef struct {
    bit          fw;
    bit [RW-1:0] rd;
    bit [31:0]   data;
  } ent_t;

  ent_t q[$];
  bit   m_ready;
  int   n_total = 0;
  int   n_bad   = 0;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Load semantics straight from the rules: pick the lane, then extend.
  function automatic bit [31:0] ref_align(input bit fw, uns, bt, hx, input int ps,
                                          input bit [63:0] d);
    longint unsigned v;
    if (fw || (!bt && !hx)) return 32'(d >> (32 * (ps / 4)));
    if (bt) begin
      v = (d >> (8 * ps)) & 64'hFF;
      if (!uns && v >= 128) v = v + 64'hFFFF_FF00;
    end else begin
      v = (d >> (16 * (ps / 2))) & 64'hFFFF;
      if (!uns && v >= 32768) v = v + 64'hFFFF_0000;
    end
    return 32'(v);
  endfunction

  task automatic drive_idle();
    v_i = 0; float_wb_i = 0; reg_id_i = '0; is_unsigned_op_i = 0; is_byte_op_i = 0;
    is_hex_op_i = 0; part_sel_i = '0; data_i = '0; int_yumi_i = 0; float_yumi_i = 0;
  endtask

  task automatic compare_all();
    bit exp_iv, exp_fv, exp_pend;
    exp_iv   = (q.size() > 0) && !q[0].fw;
    exp_fv   = (q.size() > 0) && q[0].fw;
    exp_pend = 0;
    foreach (q[i]) if (q[i].fw) exp_pend = 1;
    check_eq("ready", ready_o, m_ready);
    check_eq("count", count_o, q.size());
    check_eq("int_v", int_v_o, exp_iv);
    check_eq("float_v", float_v_o, exp_fv);
    check_eq("float_pending", float_pending_o, exp_pend);
    if (exp_iv) begin
      check_eq("int_rd", int_rd_o, q[0].rd);
      check_eq("int_data", int_data_o, q[0].data);
    end
    if (exp_fv) begin
      check_eq("float_rd", float_rd_o, q[0].rd);
      check_eq("float_data", float_data_o, q[0].data);
    end
  endtask

  task automatic check_reset_outputs();
    check_eq("rst_ready", ready_o, 0);
    check_eq("rst_count", count_o, 0);
    check_eq("rst_int_v", int_v_o, 0);
    check_eq("rst_float_v", float_v_o, 0);
    check_eq("rst_pending", float_pending_o, 0);
    check_eq("rst_int_rd", int_rd_o, 0);
    check_eq("rst_int_data", int_data_o, 0);
    check_eq("rst_float_rd", float_rd_o, 0);
    check_eq("rst_float_data", float_data_o, 0);
  endtask

  // One clock: apply inputs, advance the model across the edge, then check just after it.
  task automatic cycle(input bit v, fw, input bit [RW-1:0] rd, input bit uns, bt, hx,
                       input bit [2:0] ps, input bit [63:0] d, input bit iy, fy);
    bit   pop, enq;
    ent_t e;
    v_i = v; float_wb_i = fw; reg_id_i = rd; is_unsigned_op_i = uns; is_byte_op_i = bt;
    is_hex_op_i = hx; part_sel_i = ps; data_i = d; int_yumi_i = iy; float_yumi_i = fy;
    @(posedge clk_i);
    pop = (q.size() > 0) && ((!q[0].fw && iy) || (q[0].fw && fy));
    enq = v && m_ready;
    if (pop) void'(q.pop_front());
    if (enq) begin
      e.fw = fw; e.rd = rd; e.data = ref_align(fw, uns, bt, hx, int'(ps), d);
      q.push_back(e);
    end
    m_ready = (q.size() != ELS);
    #1;
    drive_idle();
    compare_all();
  endtask

  task automatic push(input bit fw, input bit [RW-1:0] rd, input bit uns, bt, hx,
                      input bit [2:0] ps, input bit [63:0] d, input bit iy, fy);
    cycle(1'b1, fw, rd, uns, bt, hx, ps, d, iy, fy);
  endtask

  task automatic idle(input bit iy, fy);
    cycle(1'b0, 1'b0, '0, 1'b0, 1'b0, 1'b0, 3'd0, 64'd0, iy, fy);
  endtask

  initial begin
    bit       v, fw, uns, bt, hx, iy, fy;
    int       kind;
    bit [2:0] ps;
    bit [63:0] d;

    drive_idle();
    reset_n_i = 1'b0;
    m_ready   = 0;
    #3;
    check_reset_outputs();
    @(negedge clk_i);
    reset_n_i = 1'b1;
    idle(0, 0);
    check_eq("ready_after_release", ready_o, 1);

    // Signed byte from lane 2.
    push(0, 5'd3, 0, 1, 0, 3'd2, 64'h0080_0000, 0, 0);
    check_eq("sbyte_rd", int_rd_o, 3);
    check_eq("sbyte_data", int_data_o, 32'hFFFF_FF80);
    idle(1, 0);
    check_eq("sbyte_popped", count_o, 0);

    // Upper-half hex and word selection on the 64-bit path.
    push(0, 5'd4, 1, 0, 1, 3'd6, 64'hBEEF_0000_0000_0000, 0, 0);
    check_eq("uhex_data", int_data_o, 32'h0000_BEEF);
    idle(1, 0);
    push(0, 5'd5, 0, 0, 0, 3'd4, 64'h1234_5678_9ABC_DEF0, 0, 0);
    check_eq("word_hi_data", int_data_o, 32'h1234_5678);
    idle(1, 0);

    // Float entry waits behind an int head; byte flag must not affect float extraction.
    push(0, 5'd1, 0, 0, 0, 3'd0, 64'hAAAA_5555, 0, 0);
    push(1, 5'd7, 0, 1, 0, 3'd0, 64'h3F80_0000, 0, 0);
    for (int i = 0; i < 3; i++) idle(0, 0);
    check_eq("float_blocked_v", float_v_o, 0);
    check_eq("float_blocked_pend", float_pending_o, 1);
    idle(1, 0);
    check_eq("float_head_v", float_v_o, 1);
    check_eq("float_head_data", float_data_o, 32'h3F80_0000);
    idle(0, 1);
    check_eq("float_drained_pend", float_pending_o, 0);

    // Fill to full, then steady enqueue+pop at count 2 to exercise wrap on a depth of 3.
    for (int i = 0; i < ELS; i++) push(0, 5'(10 + i), 0, 0, 0, 3'd0, 64'(32'h100 + i), 0, 0);
    check_eq("full_ready", ready_o, 0);
    check_eq("full_count", count_o, 3);
    idle(1, 0);
    for (int i = 0; i < 7; i++) begin
      push(0, 5'(20 + i), 0, 0, 0, 3'd0, 64'(32'h200 + i), 1, 0);
      check_eq("pair_count", count_o, 2);
    end
    idle(1, 0);
    idle(1, 0);

    // Asynchronous reset mid-cycle with two entries queued.
    push(0, 5'd2, 0, 0, 0, 3'd0, 64'h11, 0, 0);
    push(1, 5'd6, 0, 0, 0, 3'd0, 64'h22, 0, 0);
    #2;
    reset_n_i = 1'b0;
    #1;
    q.delete();
    m_ready = 0;
    check_reset_outputs();
    @(negedge clk_i);
    reset_n_i = 1'b1;
    idle(0, 0);
    check_eq("rerelease_ready", ready_o, 1);
    check_eq("rerelease_count", count_o, 0);

    // Randomized legal traffic.
    for (int n = 0; n < 500; n++) begin
      v    = m_ready && ($urandom_range(0, 3) != 0);
      fw   = ($urandom_range(0, 3) == 0);
      kind = $urandom_range(0, 2);
      bt   = (kind == 1);
      hx   = (kind == 2);
      uns  = $urandom_range(0, 1);
      ps   = 3'($urandom_range(0, 7));
      d    = {$urandom, $urandom};
      iy   = (q.size() > 0) && !q[0].fw && ($urandom_range(0, 1) == 1);
      fy   = (q.size() > 0) && q[0].fw && ($urandom_range(0, 1) == 1);
      cycle(v, fw, 5'($urandom_range(0, 31)), uns, bt, hx, ps, d, iy, fy);
    end

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
